// File: rtl/parity_stream_unit.sv
// parity_stream_unit: pipelined even/odd parity generator/checker on a valid/ready stream
// Tracks frames delimited by in_last and reports per-word error, per-frame error,
// overrun at MAX_BEATS and a saturating mismatch count.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode                  0 = generate, 1 = check (taken at frame start)
//   in_valid/in_ready     input handshake; in_data, in_par, in_last input fields
//   out_valid/out_ready   output handshake; out_data, out_par, out_err, out_last fields
//   frame_err, overrun    frame status, meaningful only with out_last
//   err_count             saturating count of mismatched words since reset
module parity_stream_unit #(
  parameter int DATA_W    = 8,
  parameter int ODD       = 0,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  output logic              out_last,
  output logic              frame_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  err_count
);
  typedef enum logic {IDLE, FRAME} state_t;
  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d, cnt_nxt;
  logic              acc_q, acc_d, mode_q, mode_d;
  logic              out_valid_q, out_valid_d, out_par_q, out_par_d, out_err_q, out_err_d;
  logic              out_last_q, out_last_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              idle, in_fire, p, err, ovr, last, acc_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_par_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_par_q   <= out_par_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      err_count_q <= err_count_d;
    end
  // The first word of a frame uses the live mode; later words use the latched one.
  always_comb begin
    idle     = state_q == IDLE;
    in_fire  = in_valid && in_ready;
    p        = (^in_data) ^ (ODD != 0);
    err      = (idle ? mode : mode_q) && (in_par != p);
    cnt_nxt  = idle ? 8'd1 : cnt_q + 8'd1;
    ovr      = !in_last && cnt_nxt == 8'(MAX_BEATS);
    last     = in_last || ovr;
    acc_prev = !idle && acc_q;
    state_d  = in_fire ? (last ? IDLE : FRAME) : state_q;
    cnt_d    = in_fire ? cnt_nxt : cnt_q;
    acc_d    = in_fire ? acc_prev || err : acc_q;
    mode_d   = in_fire && idle ? mode : mode_q;
  end
  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    out_valid_d = in_fire || (out_valid_q && !out_ready);
    out_data_d  = in_fire ? in_data : out_data_q;
    out_par_d   = in_fire ? p : out_par_q;
    out_err_d   = in_fire ? err : out_err_q;
    out_last_d  = in_fire ? last : out_last_q;
    frame_err_d = in_fire ? last && (acc_prev || err || ovr) : frame_err_q;
    overrun_d   = in_fire ? ovr : overrun_q;
    err_count_d = (in_fire && err && !(&err_count_q)) ? err_count_q + 1'b1 : err_count_q;
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_par   = out_par_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_parity_stream_unit.sv
// tb_parity_stream_unit: directed table plus corner sequences for parity_stream_unit
module tb_parity_stream_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mode = 1'b0, in_valid = 1'b0, in_par = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic e_ir, e_ov, e_par, e_err, e_last, e_ferr, e_ovr;
  logic o_ir, o_ov, o_par, o_err, o_last, o_ferr, o_ovr;
  logic [7:0] e_data, o_data, e_cnt;
  logic [1:0] o_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  parity_stream_unit ue (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(e_ir),
    .in_data(in_data), .in_par(in_par), .in_last(in_last), .out_valid(e_ov),
    .out_ready(out_ready), .out_data(e_data), .out_par(e_par), .out_err(e_err),
    .out_last(e_last), .frame_err(e_ferr), .overrun(e_ovr), .err_count(e_cnt));
  parity_stream_unit #(.DATA_W(8), .ODD(1), .MAX_BEATS(4), .CNT_W(2)) uo (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(o_ir),
    .in_data(in_data), .in_par(in_par), .in_last(in_last), .out_valid(o_ov),
    .out_ready(out_ready), .out_data(o_data), .out_par(o_par), .out_err(o_err),
    .out_last(o_last), .frame_err(o_ferr), .overrun(o_ovr), .err_count(o_cnt));
  typedef struct {
    logic       mode;
    logic [7:0] data;
    logic       par, last;
    logic       e_par, e_err, e_last, e_ferr;
    logic [7:0] e_cnt;
    logic       o_par, o_err, o_last, o_ferr, o_ovr;
    logic [1:0] o_cnt;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic m, input logic [7:0] d, input logic p, input logic l);
    mode = m; in_data = d; in_par = p; in_last = l; in_valid = 1'b1;
  endtask
  initial begin
    // saturation on the odd/CNT_W=2 unit: single-word check frames, each mismatched there
    for (int k = 0; k < 5; k++)
      tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,
                      1'b1, 1'b1, 1'b1, 1'b1, 1'b0, (k < 3) ? 2'(k + 1) : 2'd3});
    // generate frame; mode flip on word 2 must be ignored
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3});
    // check frame: error on word 1 (odd) accumulates into frame_err on word 2
    tbl.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3});
    // eight words without last: overrun on words 4 and 8 of the MAX_BEATS=4 unit
    tbl.push_back('{1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1'b0, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3});
    tbl.push_back('{1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3});
    tbl.push_back('{1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3});
    // reset state
    #12;
    chk("rst_e_valid", e_ov, 0); chk("rst_o_valid", o_ov, 0);
    chk("rst_e_cnt", e_cnt, 0); chk("rst_o_cnt", o_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", e_ir, 1); chk("rst_o_out_last", o_last, 0);
    // table: one word per cycle, out_ready high, one-cycle latency
    foreach (tbl[i]) begin
      drive(tbl[i].mode, tbl[i].data, tbl[i].par, tbl[i].last);
      @(posedge clk); #1;
      chk($sformatf("v%0d_e_valid", i), e_ov, 1);
      chk($sformatf("v%0d_e_data", i), e_data, tbl[i].data);
      chk($sformatf("v%0d_e_par", i), e_par, tbl[i].e_par);
      chk($sformatf("v%0d_e_err", i), e_err, tbl[i].e_err);
      chk($sformatf("v%0d_e_last", i), e_last, tbl[i].e_last);
      chk($sformatf("v%0d_e_ferr", i), e_ferr, tbl[i].e_ferr);
      chk($sformatf("v%0d_e_ovr", i), e_ovr, 0);
      chk($sformatf("v%0d_e_cnt", i), e_cnt, tbl[i].e_cnt);
      chk($sformatf("v%0d_o_par", i), o_par, tbl[i].o_par);
      chk($sformatf("v%0d_o_err", i), o_err, tbl[i].o_err);
      chk($sformatf("v%0d_o_last", i), o_last, tbl[i].o_last);
      chk($sformatf("v%0d_o_ferr", i), o_ferr, tbl[i].o_ferr);
      chk($sformatf("v%0d_o_ovr", i), o_ovr, tbl[i].o_ovr);
      chk($sformatf("v%0d_o_cnt", i), o_cnt, tbl[i].o_cnt);
    end
    // drain: no new word means out_valid drops
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", e_ov, 0);
    // backpressure: first word held, second waits, then both emerge in order
    out_ready = 1'b0;
    drive(1'b0, 8'h5A, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 8'hC3, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_valid", c), e_ov, 1);
      chk($sformatf("bp%0d_data", c), e_data, 8'h5A);
      chk($sformatf("bp%0d_par", c), e_par, 0);
      chk($sformatf("bp%0d_in_ready", c), e_ir, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", e_ir, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_valid", e_ov, 1);
    chk("bp_second_data", e_data, 8'hC3);
    chk("bp_second_par", e_par, 0);
    @(posedge clk); #1;
    chk("bp_empty", e_ov, 0);
    // async reset mid-frame with a held output word
    drive(1'b0, 8'h11, 1'b0, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b0, 8'h13, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", o_ov, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", o_ov, 0); chk("arst_data", o_data, 0);
    chk("arst_par", o_par, 0); chk("arst_last", o_last, 0);
    chk("arst_e_cnt", e_cnt, 0); chk("arst_o_cnt", o_cnt, 0);
    chk("arst_in_ready", o_ir, 1);
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_o_err", o_err, 1); chk("post_o_ferr", o_ferr, 1);
    chk("post_o_last", o_last, 1); chk("post_o_cnt", o_cnt, 1);
    chk("post_e_err", e_err, 0); chk("post_e_cnt", e_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
